// File: rtl/way_allocator.sv
// way_allocator: per-set valid bits and round-robin victim pointers; returns the fill way for each allocation.
// Optional whole-cache flush (FSM, set counter, flush_busy) is compiled in when WAY_ALLOCATOR_FLUSH_EN is defined.
module way_allocator #(
  parameter  int NWAYS = 5,
  parameter  int NSETS = 16,
  localparam int WW    = $clog2(NWAYS),
  localparam int SW    = $clog2(NSETS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_req,
  input  logic [SW-1:0] alloc_set,
  output logic          alloc_ready,
  output logic          alloc_valid,
  output logic [WW-1:0] alloc_way,
  output logic          alloc_evict,
  input  logic          inv_req,
  input  logic [SW-1:0] inv_set,
  input  logic [WW-1:0] inv_way,
  input  logic          flush_req,
  output logic          flush_busy
);

  logic [NWAYS-1:0] valid_q [NSETS];
  logic [NWAYS-1:0] valid_d [NSETS];
  logic [WW-1:0]    rr_q    [NSETS];
  logic [WW-1:0]    rr_d    [NSETS];

  logic          alloc_valid_q;
  logic [WW-1:0] alloc_way_q;
  logic          alloc_evict_q;

  logic          accept;
  logic          alloc_set_ok;
  logic          inv_ok;
  logic          set_full;
  logic          free_found;
  logic [NWAYS-1:0] cur_valid;
  logic [WW-1:0] free_way;
  logic [WW-1:0] sel_way;
  logic          sel_evict;
  logic [WW-1:0] rr_cur;
  logic [WW-1:0] rr_next;
  logic          clear_en;
  logic [SW-1:0] clear_set;

`ifdef WAY_ALLOCATOR_FLUSH_EN
  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == SW'(NSETS - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_busy  = (state_q == FLUSH);
  assign clear_en    = flush_busy;
  assign clear_set   = cnt_q;
  assign alloc_ready = rst_n && !flush_busy && !flush_req;
`else
  logic unused_flush_req;

  assign unused_flush_req = flush_req;
  assign flush_busy       = 1'b0;
  assign clear_en         = 1'b0;
  assign clear_set        = '0;
  assign alloc_ready      = rst_n;
`endif

  // Out-of-range sets read as an empty set, which yields way 0 with no eviction.
  assign accept       = alloc_req && alloc_ready;
  assign alloc_set_ok = (int'(alloc_set) < NSETS);
  assign inv_ok       = inv_req && !clear_en && (int'(inv_set) < NSETS) && (int'(inv_way) < NWAYS);

  always_comb begin
    cur_valid  = '0;
    rr_cur     = '0;
    free_way   = '0;
    free_found = 1'b0;
    if (alloc_set_ok) begin
      cur_valid = valid_q[alloc_set];
      rr_cur    = rr_q[alloc_set];
    end
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!cur_valid[i]) begin
        free_found = 1'b1;
        free_way   = WW'(i);
      end
    end
    set_full  = !free_found;
    sel_way   = set_full ? rr_cur : free_way;
    sel_evict = set_full;
    rr_next   = (rr_cur == WW'(NWAYS - 1)) ? '0 : rr_cur + 1'b1;
  end

  // Allocation is applied after invalidation so it wins on a same-line collision.
  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    if (clear_en) begin
      valid_d[clear_set] = '0;
      rr_d[clear_set]    = '0;
    end
    if (inv_ok) begin
      valid_d[inv_set][inv_way] = 1'b0;
    end
    if (accept && alloc_set_ok) begin
      valid_d[alloc_set][sel_way] = 1'b1;
      if (set_full) begin
        rr_d[alloc_set] = rr_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      alloc_valid_q <= 1'b0;
      alloc_way_q   <= '0;
      alloc_evict_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rr_q          <= rr_d;
      alloc_valid_q <= accept;
      if (accept) begin
        alloc_way_q   <= sel_way;
        alloc_evict_q <= sel_evict;
      end
    end
  end

  assign alloc_valid = alloc_valid_q;
  assign alloc_way   = alloc_way_q;
  assign alloc_evict = alloc_evict_q;

endmodule

// File: tb/tb_way_allocator.sv
// tb_way_allocator: directed stimulus with a set-level behavioural model checked every cycle,
// plus literal expectations for fill, round-robin wrap, invalidation, flush and asynchronous reset.
module tb_way_allocator;
  localparam int NWAYS = 5;
  localparam int NSETS = 16;
  localparam int WW    = $clog2(NWAYS);
  localparam int SW    = $clog2(NSETS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_req;
  logic [SW-1:0] alloc_set;
  logic          alloc_ready;
  logic          alloc_valid;
  logic [WW-1:0] alloc_way;
  logic          alloc_evict;
  logic          inv_req;
  logic [SW-1:0] inv_set;
  logic [WW-1:0] inv_way;
  logic          flush_req;
  logic          flush_busy;

  int testsRun    = 0;
  int testsFailed = 0;

  way_allocator #(.NWAYS(NWAYS), .NSETS(NSETS)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_set(alloc_set), .alloc_ready(alloc_ready),
    .alloc_valid(alloc_valid), .alloc_way(alloc_way), .alloc_evict(alloc_evict),
    .inv_req(inv_req), .inv_set(inv_set), .inv_way(inv_way),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  // Model: cache lines as a boolean table, victim pointer as an integer, flush as a countdown.
  bit mValid [NSETS][NWAYS];
  int mPtr [NSETS];
  int mFlushLeft;
  bit expValid;
  int expWay;
  bit expEvict;
  bit mAccept;
  int mSet;
  int mWay;
  int mUsed;
  bit mFound;

  task automatic checkVal(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit modelReady();
`ifdef WAY_ALLOCATOR_FLUSH_EN
    return (mFlushLeft == 0) && !flush_req;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSETS; s++) begin
        mPtr[s] = 0;
        for (int w = 0; w < NWAYS; w++) mValid[s][w] = 1'b0;
      end
      mFlushLeft = 0;
      expValid   = 1'b0;
      expWay     = 0;
      expEvict   = 1'b0;
    end else begin
      mAccept  = alloc_req && modelReady();
      expValid = mAccept;
      mSet     = int'(alloc_set);
      if (mAccept) begin
        mWay = 0;
        expEvict = 1'b0;
        if (mSet < NSETS) begin
          mUsed = 0;
          mFound = 1'b0;
          for (int w = 0; w < NWAYS; w++) begin
            if (mValid[mSet][w]) mUsed++;
            else if (!mFound) begin
              mFound = 1'b1;
              mWay = w;
            end
          end
          if (mUsed == NWAYS) begin
            mWay = mPtr[mSet];
            expEvict = 1'b1;
            mPtr[mSet] = (mPtr[mSet] + 1) % NWAYS;
          end
        end
        expWay = mWay;
      end
      if (mFlushLeft == 0 && inv_req && int'(inv_set) < NSETS && int'(inv_way) < NWAYS)
        mValid[int'(inv_set)][int'(inv_way)] = 1'b0;
      if (mAccept && mSet < NSETS)
        mValid[mSet][mWay] = 1'b1;
`ifdef WAY_ALLOCATOR_FLUSH_EN
      if (mFlushLeft > 0) begin
        mFlushLeft--;
      end else if (flush_req) begin
        mFlushLeft = NSETS;
        for (int s = 0; s < NSETS; s++) begin
          mPtr[s] = 0;
          for (int w = 0; w < NWAYS; w++) mValid[s][w] = 1'b0;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkVal("model alloc_valid", alloc_valid, expValid);
      checkVal("model alloc_way", alloc_way, expWay);
      checkVal("model alloc_evict", alloc_evict, expEvict);
      checkVal("model alloc_ready", alloc_ready, modelReady());
      checkVal("model flush_busy", flush_busy, mFlushLeft > 0);
    end
  end

  task automatic applyStimulus(input bit req, input int aset, input bit inv, input int iset,
                               input int iway, input bit flush);
    alloc_req = req;
    alloc_set = SW'(aset);
    inv_req   = inv;
    inv_set   = SW'(iset);
    inv_way   = WW'(iway);
    flush_req = flush;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int wayLit, input int evictLit);
    checkVal({name, " valid"}, alloc_valid, 1);
    checkVal({name, " way"}, alloc_way, wayLit);
    checkVal({name, " evict"}, alloc_evict, evictLit);
  endtask

  task automatic allocCheck(input string name, input int aset, input int wayLit, input int evictLit);
    applyStimulus(1'b1, aset, 1'b0, 0, 0, 1'b0);
    checkOutput(name, wayLit, evictLit);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  int fillWays [7] = '{0, 1, 2, 3, 4, 0, 1};

  initial begin
    rst_n = 1'b0;
    alloc_req = 1'b0; alloc_set = '0;
    inv_req = 1'b0; inv_set = '0; inv_way = '0;
    flush_req = 1'b0;
    #12;
    checkVal("reset alloc_valid", alloc_valid, 0);
    checkVal("reset alloc_way", alloc_way, 0);
    checkVal("reset alloc_evict", alloc_evict, 0);
    checkVal("reset flush_busy", flush_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkVal("ready after reset", alloc_ready, 1);

    alloc_req = 1'b1; alloc_set = SW'(3);
    #1;
    checkVal("no result before edge", alloc_valid, 0);
    for (int i = 0; i < NWAYS; i++) allocCheck($sformatf("fill%0d", i), 3, i, 0);
    for (int i = 0; i < 7; i++) allocCheck($sformatf("evict%0d", i), 3, fillWays[i], 1);
    idle();
    checkVal("valid drops when idle", alloc_valid, 0);
    checkVal("way held when idle", alloc_way, 1);
    allocCheck("set4 independent", 4, 0, 0);

    applyStimulus(1'b0, 0, 1'b1, 3, 2, 1'b0);
    allocCheck("refill after inv", 3, 2, 0);
    allocCheck("ptr unchanged by inv", 3, 2, 1);

    applyStimulus(1'b0, 0, 1'b1, 3, 2, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 3, 4, 1'b0);
    applyStimulus(1'b1, 3, 1'b1, 3, 2, 1'b0);
    checkOutput("alloc with same-line inv", 2, 0);
    allocCheck("alloc wins collision", 3, 4, 0);
    allocCheck("victim after collision", 3, 3, 1);

    applyStimulus(1'b0, 0, 1'b1, 4, 5, 1'b0);
    allocCheck("inv way out of range", 4, 1, 0);
    allocCheck("before async reset", 4, 2, 0);

    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async reset alloc_valid", alloc_valid, 0);
    checkVal("async reset alloc_way", alloc_way, 0);
    checkVal("async reset alloc_evict", alloc_evict, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    allocCheck("empty after reset", 3, 0, 0);

`ifdef WAY_ALLOCATOR_FLUSH_EN
    applyStimulus(1'b1, 3, 1'b0, 0, 0, 1'b1);
    checkVal("flush blocks alloc", alloc_valid, 0);
    checkVal("flush busy cycle 1", flush_busy, 1);
    for (int i = 2; i <= NSETS; i++) begin
      idle();
      checkVal($sformatf("flush busy cycle %0d", i), flush_busy, 1);
      checkVal($sformatf("flush ready cycle %0d", i), alloc_ready, 0);
    end
    idle();
    checkVal("flush done busy", flush_busy, 0);
    checkVal("flush done ready", alloc_ready, 1);
    allocCheck("empty after flush", 3, 0, 0);
    allocCheck("before mid-flush reset", 3, 1, 0);

    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) idle();
    checkVal("flush running at cycle 5", flush_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("mid-flush reset busy", flush_busy, 0);
    checkVal("mid-flush reset alloc_way", alloc_way, 0);
    checkVal("mid-flush reset alloc_valid", alloc_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    checkVal("busy after reset release", flush_busy, 0);
    allocCheck("empty after mid-flush reset", 3, 0, 0);
`else
    applyStimulus(1'b1, 3, 1'b0, 0, 0, 1'b1);
    checkOutput("alloc ignores flush_req", 1, 0);
    checkVal("no flush busy", flush_busy, 0);
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);
    checkVal("flush pulse busy", flush_busy, 0);
    checkVal("flush pulse ready", alloc_ready, 1);
    allocCheck("state kept after flush_req", 3, 2, 0);
`endif

    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/way_allocator.md
# way_allocator

Sequential, multi-set successor to the combinational write-way selection in the cache. Holds per-set valid bits and a per-set round-robin victim pointer. On each accepted allocation request it returns the way to fill: the lowest invalid way, or a round-robin victim when the set is full. Sits between the cache controller's miss handler and the tag/data arrays, and also services single-line invalidations and an optional whole-cache flush.

## Interface
- `NWAYS`, default 5: ways per set; any value ≥ 2, not required to be a power of two.
- `NSETS`, default 16: number of sets; any value ≥ 2.
- Derived widths: `WW = $clog2(NWAYS)`, `SW = $clog2(NSETS)`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `alloc_req`  in  1: allocation request.
- `alloc_set`  in  SW: set index of the request.
- `alloc_ready`  out  1: block accepts a request this cycle.
- `alloc_valid`  out  1: one-cycle pulse; the allocation result is valid.
- `alloc_way`  out  WW: way chosen.
- `alloc_evict`  out  1: the chosen way held valid data and must be written back or dropped.
- `inv_req`  in  1: invalidate one line.
- `inv_set`  in  SW: set index for invalidation.
- `inv_way`  in  WW: way index for invalidation.
- `flush_req`  in  1: start a whole-cache flush.
- `flush_busy`  out  1: flush in progress.

## Operation
- Per-set state:
  - `valid[NSETS][NWAYS]`, reset to all 0.
  - `rr_ptr[NSETS]` (WW bits), reset to 0.
- Accept condition: `alloc_req && alloc_ready`. Selection uses the state as it stands before the clock edge.
  - If any valid bit in the set is 0: way = lowest index i with `valid[set][i] == 0`; `alloc_evict = 0`; `rr_ptr` unchanged.
  - If the set is full: way = `rr_ptr[set]`; `alloc_evict = 1`; `rr_ptr[set]` advances by 1 and wraps from NWAYS-1 to 0.
  - In both cases `valid[set][way]` is set to 1.
- Invalidation: `inv_req` clears `valid[inv_set][inv_way]`.
  - `inv_way ≥ NWAYS` is ignored.
  - `rr_ptr` is unaffected.
  - Invalidation needs no handshake and is serviced every cycle in IDLE.
- Simultaneous allocation and invalidation:
  - Both take effect at the same edge.
  - The allocation selection ignores the same-cycle invalidation.
  - If both target the same set and way, the allocation wins and the bit ends at 1.
- Out-of-range `alloc_set` / `inv_set` (NSETS not a power of two): the request is ignored. `alloc_valid` still pulses with `alloc_way = 0` and `alloc_evict = 0`.
- FSM with two states, IDLE and FLUSH:
  - IDLE → FLUSH on `flush_req`. Flush has priority: if `alloc_req` is also high that cycle, it is not accepted, because `alloc_ready` is combinationally low while `flush_req` is high in IDLE.
  - In FLUSH, an internal set counter clears `valid[cnt]` and `rr_ptr[cnt]`, one set per cycle, for cnt = 0 to NSETS-1.
  - On the final set the FSM returns to IDLE.
  - `inv_req` and `flush_req` are ignored in FLUSH.

## Timing
- Allocation latency is 1 cycle. A request accepted at edge N gives `alloc_valid = 1` with `alloc_way` and `alloc_evict` registered during cycle N+1. State updates land at edge N.
- Throughput is one allocation per cycle. A back-to-back request to the same set sees the updated state, with no bubble.
- `alloc_way` and `alloc_evict` hold their last value when `alloc_valid = 0`.
- Flush:
  - `flush_busy` is high for exactly NSETS cycles, starting the cycle after `flush_req` is sampled.
  - `alloc_ready = !flush_busy && !flush_req`.
  - The first allocation accepted after flush sees all sets empty.
- Reset values, asserted asynchronously:
  - `alloc_valid = 0`, `alloc_way = 0`, `alloc_evict = 0`, `flush_busy = 0`.
  - `alloc_ready = 1` once `rst_n` is high and no flush is requested.
  - FSM = IDLE; all valid bits and pointers are 0.
  - Reset asserted mid-flush aborts the flush immediately.

## Configuration
- Macro: `WAY_ALLOCATOR_FLUSH_EN`.
- Defined: the FLUSH state, set counter, `flush_busy` and the `flush_req` gating described above are compiled in.
- Undefined:
  - No FSM or counter is built.
  - `flush_req` is ignored.
  - `flush_busy` is tied to 0.
  - `alloc_ready = 1` except during reset.
  - State clears only on reset; all other behaviour is identical.

## Test plan
- Fill (NWAYS=5, NSETS=16): after reset, 5 allocations to set 3 → ways 0,1,2,3,4, all with evict=0; each result appears 1 cycle after acceptance.
- Full set: 7 further allocations to set 3 → ways 0,1,2,3,4,0,1, all with evict=1. Checks wrap at 4→0. Set 4 is unaffected: its first allocation returns way 0 with evict=0.
- Invalidation: set 3 full, `inv_req` for set 3 way 2, then allocate set 3 → way 2, evict=0, and `rr_ptr` is unchanged. Same-cycle allocation and invalidation to (set 3, way 2) on a set where way 2 is the lowest invalid way → bit ends at 1.
- Simultaneous requests: `flush_req` and `alloc_req` high together → allocation not accepted. `flush_busy` is high for 16 cycles and `alloc_ready` is 0 throughout. The next allocation to set 3 returns way 0 with evict=0.
- Reset mid-flush: drop `rst_n` at flush cycle 5 → all outputs reach their reset values asynchronously. After release, `flush_busy = 0` and the state is empty.
- Macro undefined: `flush_req` pulse → `flush_busy` stays 0, `alloc_ready` stays 1, valid state is retained.
